fwd_hazard_unit: RTL and testbench
==================================

Name: fwd_hazard_unit

Overview:
Parametrised successor to the EX-stage forwarder. It generalises forwarding to NUM_SRC source operands and a configurable register-address width, and adds a third forwarding source: the writeback retired one cycle earlier (WB2), for regfiles without internal write-before-read bypass. It also adds load-use stall detection, a memory-wait freeze, and saturating stall counters. It sits beside the ID/EX pipeline registers and drives the EX operand muxes and the pipeline stall/bubble controls.

Parameters:
REG_AW, 3, register address width
NUM_SRC, 2, source operands per instruction
ZERO_HARDWIRED, 0, if 1 register 0 never forwards and never causes hazards
RF_BYPASS, 1, if 0 enable WB2 forwarding (regfile lacks write-before-read)
CNT_W, 16, stall counter width

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
ID_rsrc  in  NUM_SRC*REG_AW  ID source regs; operand i occupies bits [i*REG_AW +: REG_AW]
ID_rsrc_valid  in  NUM_SRC  ID operand i is actually read
EX_rsrc  in  NUM_SRC*REG_AW  EX source regs, same packing
EX_rO, EX_rf_wen, EX_is_load  in  REG_AW,1,1  EX-stage destination, write enable, load flag
MEM_rO, MEM_rf_wen, MEM_is_load  in  REG_AW,1,1  MEM-stage destination, write enable, load flag
MEM_busy  in  1  data memory not ready (miss/multicycle)
WB_rO, WB_rf_wen  in  REG_AW,1  WB-stage destination and write enable
fwd_sel  out  2*NUM_SRC  per-operand select: 00 PASS, 01 MEM, 10 WB, 11 WB2
stall_id  out  1  hold PC and IF/ID
bubble_ex  out  1  inject NOP into ID/EX
freeze_all  out  1  hold every pipeline register
lu_stall_cnt  out  CNT_W  load-use stall cycles
mem_stall_cnt  out  CNT_W  memory-wait cycles

Behaviour:
- Forward select (combinational, per operand i, strict priority): MEM match (MEM_rf_wen, !MEM_is_load, MEM_rO==EX_rsrc[i]) -> 01; WB match -> 10; WB2 match (RF_BYPASS==0, wb2_v, wb2_rO==EX_rsrc[i]) -> 11; else 00.
- MEM load match yields 00. The load-use stall guarantees this is architecturally unreachable; an assertion flags it in simulation.
- ZERO_HARDWIRED=1: any operand or destination equal to 0 never matches.
- WB2 register: {wb2_v, wb2_rO} <= {WB_rf_wen, WB_rO} on each clk edge where freeze_all==0. It holds when frozen. Reset value is 0.
- Load-use hazard lu = any i with ID_rsrc_valid[i] && EX_rf_wen && EX_is_load && EX_rO==ID_rsrc[i].
- FSM states (2-bit, registered), reset to RUN:
  - RUN: if MEM_busy -> MWAIT. Else if lu -> LU (stall_id=1, bubble_ex=1 combinationally in this cycle). Else stay.
  - LU: all outputs deasserted (the load is now in MEM, so no repeat stall). If MEM_busy -> MWAIT, else -> RUN.
  - MWAIT: freeze_all=1; stall_id and bubble_ex are 0. Exit to RUN on the first cycle MEM_busy==0; freeze_all drops that same cycle (freeze_all = MEM_busy in any state).
- Priority: MEM_busy and lu in the same cycle -> freeze_all=1 only. lu is re-evaluated after the freeze, so no stall is lost.
- Counters: lu_stall_cnt increments on each cycle stall_id==1. mem_stall_cnt increments on each cycle freeze_all==1. Both saturate at all-ones and do not wrap.
- Reset mid-operation: FSM -> RUN, WB2 cleared, counters -> 0. All outputs go to 0 immediately (asynchronous). Combinational fwd_sel reflects inputs as soon as reset deasserts.
- Every registered output and all state reset to 0.

Test Plan:
- Priority: EX_rsrc0=3; MEM_rO=3/wen=1, WB_rO=3/wen=1 -> fwd_sel[1:0]=01. Drop MEM_rf_wen -> 10. Drop WB_rf_wen -> 00.
- Load-use: EX_is_load=1, EX_rO=5, ID_rsrc1=5 valid -> stall_id=bubble_ex=1 for exactly 1 cycle, lu_stall_cnt=1. Repeat with ID_rsrc_valid[1]=0 -> no stall.
- WB2 (RF_BYPASS=0): WB writes r2 at cycle n; EX_rsrc0=2 at n+1 with no MEM/WB match -> fwd_sel[1:0]=11. With RF_BYPASS=1 -> 00.
- Memory wait: MEM_busy high 4 cycles coincident with lu -> freeze_all=1 for 4 cycles, mem_stall_cnt=4, no stall_id during freeze. Load-use stall follows in the next cycle.
- Saturation/reset: CNT_W=4, 20 busy cycles -> mem_stall_cnt=15. Assert rst in MWAIT -> all outputs 0 asynchronously, FSM=RUN.
- ZERO_HARDWIRED=1, NUM_SRC=3, REG_AW=4: MEM_rO=0 matches EX operand 0 -> 00. Match on operand 2 (reg 9) -> fwd_sel[5:4]=01.

Source files
------------

// File: rtl/fwd_hazard_unit.sv
// ---------------------------------------------------------------------------
// fwd_hazard_unit
//
// Selects the forwarding source for each EX-stage operand, detects
// load-use hazards between ID and EX, and freezes the whole pipeline
// while data memory is busy. Two saturating counters record lost cycles.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   ID_rsrc           ID source registers, operand i at [i*REG_AW +: REG_AW]
//   ID_rsrc_valid     ID operand i is actually read
//   EX_rsrc           EX source registers, same packing as ID_rsrc
//   EX_rO/_rf_wen/_is_load    EX destination, write enable, load flag
//   MEM_rO/_rf_wen/_is_load   MEM destination, write enable, load flag
//   MEM_busy          data memory not ready
//   WB_rO/_rf_wen     WB destination and write enable
//   fwd_sel           2 bits per operand: 00 PASS, 01 MEM, 10 WB, 11 WB2
//   stall_id          hold PC and IF/ID
//   bubble_ex         inject a NOP into ID/EX
//   freeze_all        hold every pipeline register
//   lu_stall_cnt      cycles spent in load-use stall
//   mem_stall_cnt     cycles spent waiting on memory
// ---------------------------------------------------------------------------
module fwd_hazard_unit #(
    parameter int REG_AW         = 3,
    parameter int NUM_SRC        = 2,
    parameter int ZERO_HARDWIRED = 0,
    parameter int RF_BYPASS      = 1,
    parameter int CNT_W          = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_SRC*REG_AW-1:0]   ID_rsrc,
    input  logic [NUM_SRC-1:0]          ID_rsrc_valid,
    input  logic [NUM_SRC*REG_AW-1:0]   EX_rsrc,
    input  logic [REG_AW-1:0]           EX_rO,
    input  logic                        EX_rf_wen,
    input  logic                        EX_is_load,
    input  logic [REG_AW-1:0]           MEM_rO,
    input  logic                        MEM_rf_wen,
    input  logic                        MEM_is_load,
    input  logic                        MEM_busy,
    input  logic [REG_AW-1:0]           WB_rO,
    input  logic                        WB_rf_wen,
    output logic [2*NUM_SRC-1:0]        fwd_sel,
    output logic                        stall_id,
    output logic                        bubble_ex,
    output logic                        freeze_all,
    output logic [CNT_W-1:0]            lu_stall_cnt,
    output logic [CNT_W-1:0]            mem_stall_cnt
);

    localparam logic [1:0] SEL_PASS = 2'b00;
    localparam logic [1:0] SEL_MEM  = 2'b01;
    localparam logic [1:0] SEL_WB   = 2'b10;
    localparam logic [1:0] SEL_WB2  = 2'b11;

    typedef enum logic [1:0] {
        S_RUN   = 2'b00,
        S_LU    = 2'b01,
        S_MWAIT = 2'b10
    } state_t;

    state_t              state, state_nxt;
    logic                wb2_vld_p1;
    logic [REG_AW-1:0]   wb2_ro_p1;
    logic                lu;
    logic [NUM_SRC-1:0]  mem_load_hit;

    // A writer matches a reader when it writes and the addresses agree;
    // with a hardwired zero register, r0 never produces a match.
    function automatic logic reg_hit(input logic             wen,
                                     input logic [REG_AW-1:0] dst,
                                     input logic [REG_AW-1:0] src);
        logic zero_blk;
        zero_blk = (ZERO_HARDWIRED != 0) && (dst == '0);
        return wen && (dst == src) && !zero_blk;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + CNT_W'(1);
    endfunction

    // ---- EX operand forward select ----
    always_comb begin
        fwd_sel      = '0;
        mem_load_hit = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (reg_hit(MEM_rf_wen, MEM_rO, EX_rsrc[i*REG_AW +: REG_AW])) begin
                // A load in MEM has no data yet; the load-use stall keeps
                // this case from ever being needed, so it stays PASS.
                if (MEM_is_load)
                    mem_load_hit[i] = 1'b1;
                else
                    fwd_sel[2*i +: 2] = SEL_MEM;
            end else if (reg_hit(WB_rf_wen, WB_rO, EX_rsrc[i*REG_AW +: REG_AW])) begin
                fwd_sel[2*i +: 2] = SEL_WB;
            end else if ((RF_BYPASS == 0) &&
                         reg_hit(wb2_vld_p1, wb2_ro_p1, EX_rsrc[i*REG_AW +: REG_AW])) begin
                fwd_sel[2*i +: 2] = SEL_WB2;
            end else begin
                fwd_sel[2*i +: 2] = SEL_PASS;
            end
        end
        if (rst)
            fwd_sel = '0;
    end

    // ---- load-use hazard between ID readers and an EX load ----
    always_comb begin
        lu = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (ID_rsrc_valid[i] &&
                reg_hit(EX_rf_wen && EX_is_load, EX_rO, ID_rsrc[i*REG_AW +: REG_AW]))
                lu = 1'b1;
        end
    end

    // ---- hazard FSM: next state and control outputs ----
    // The cycle in which MWAIT sees MEM_busy drop is treated like RUN, so a
    // load-use hazard held across the freeze stalls immediately afterwards.
    always_comb begin
        state_nxt  = state;
        stall_id   = 1'b0;
        bubble_ex  = 1'b0;
        freeze_all = MEM_busy;
        case (state)
            S_RUN, S_MWAIT: begin
                if (MEM_busy) begin
                    state_nxt = S_MWAIT;
                end else if (lu) begin
                    stall_id  = 1'b1;
                    bubble_ex = 1'b1;
                    state_nxt = S_LU;
                end else begin
                    state_nxt = S_RUN;
                end
            end
            S_LU:    state_nxt = MEM_busy ? S_MWAIT : S_RUN;
            default: state_nxt = S_RUN;
        endcase
        if (rst) begin
            stall_id   = 1'b0;
            bubble_ex  = 1'b0;
            freeze_all = 1'b0;
        end
    end

    // ---- registered state: FSM, WB2 history, stall counters ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= S_RUN;
            wb2_vld_p1    <= 1'b0;
            wb2_ro_p1     <= '0;
            lu_stall_cnt  <= '0;
            mem_stall_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (!freeze_all) begin
                wb2_vld_p1 <= WB_rf_wen;
                wb2_ro_p1  <= WB_rO;
            end
            if (stall_id)
                lu_stall_cnt <= sat_inc(lu_stall_cnt);
            if (freeze_all)
                mem_stall_cnt <= sat_inc(mem_stall_cnt);
        end
    end

    a_no_mem_load_fwd : assert property (@(posedge clk) disable iff (rst)
                                         mem_load_hit == '0);

endmodule

// File: tb/tb_fwd_hazard_unit.sv
module tb_fwd_hazard_unit;

    logic clk;
    logic rst;

    // shared stimulus for instances a (WB2 enabled) and b (RF bypass, CNT_W=4)
    logic [5:0] id_rsrc, ex_rsrc;
    logic [1:0] id_vld;
    logic [2:0] ex_ro, mem_ro, wb_ro;
    logic       ex_wen, ex_ld, mem_wen, mem_ld, mem_busy, wb_wen;

    logic [3:0]  fsel_a, fsel_b;
    logic        stall_a, bub_a, frz_a, stall_b, bub_b, frz_b;
    logic [15:0] lucnt_a, memcnt_a;
    logic [3:0]  lucnt_b, memcnt_b;

    // instance c: zero hardwired, three operands, 4-bit addresses
    logic [11:0] c_id_rsrc, c_ex_rsrc;
    logic [2:0]  c_id_vld;
    logic [3:0]  c_ex_ro, c_mem_ro, c_wb_ro;
    logic        c_ex_wen, c_ex_ld, c_mem_wen, c_mem_ld, c_mem_busy, c_wb_wen;
    logic [5:0]  fsel_c;
    logic        stall_c, bub_c, frz_c;
    logic [15:0] lucnt_c, memcnt_c;

    int compared;
    int mismatched;

    fwd_hazard_unit #(.REG_AW(3), .NUM_SRC(2), .ZERO_HARDWIRED(0), .RF_BYPASS(0), .CNT_W(16)) u_a (
        .clk(clk), .rst(rst), .ID_rsrc(id_rsrc), .ID_rsrc_valid(id_vld), .EX_rsrc(ex_rsrc),
        .EX_rO(ex_ro), .EX_rf_wen(ex_wen), .EX_is_load(ex_ld),
        .MEM_rO(mem_ro), .MEM_rf_wen(mem_wen), .MEM_is_load(mem_ld), .MEM_busy(mem_busy),
        .WB_rO(wb_ro), .WB_rf_wen(wb_wen), .fwd_sel(fsel_a), .stall_id(stall_a),
        .bubble_ex(bub_a), .freeze_all(frz_a), .lu_stall_cnt(lucnt_a), .mem_stall_cnt(memcnt_a));

    fwd_hazard_unit #(.REG_AW(3), .NUM_SRC(2), .ZERO_HARDWIRED(0), .RF_BYPASS(1), .CNT_W(4)) u_b (
        .clk(clk), .rst(rst), .ID_rsrc(id_rsrc), .ID_rsrc_valid(id_vld), .EX_rsrc(ex_rsrc),
        .EX_rO(ex_ro), .EX_rf_wen(ex_wen), .EX_is_load(ex_ld),
        .MEM_rO(mem_ro), .MEM_rf_wen(mem_wen), .MEM_is_load(mem_ld), .MEM_busy(mem_busy),
        .WB_rO(wb_ro), .WB_rf_wen(wb_wen), .fwd_sel(fsel_b), .stall_id(stall_b),
        .bubble_ex(bub_b), .freeze_all(frz_b), .lu_stall_cnt(lucnt_b), .mem_stall_cnt(memcnt_b));

    fwd_hazard_unit #(.REG_AW(4), .NUM_SRC(3), .ZERO_HARDWIRED(1), .RF_BYPASS(1), .CNT_W(16)) u_c (
        .clk(clk), .rst(rst), .ID_rsrc(c_id_rsrc), .ID_rsrc_valid(c_id_vld), .EX_rsrc(c_ex_rsrc),
        .EX_rO(c_ex_ro), .EX_rf_wen(c_ex_wen), .EX_is_load(c_ex_ld),
        .MEM_rO(c_mem_ro), .MEM_rf_wen(c_mem_wen), .MEM_is_load(c_mem_ld), .MEM_busy(c_mem_busy),
        .WB_rO(c_wb_ro), .WB_rf_wen(c_wb_wen), .fwd_sel(fsel_c), .stall_id(stall_c),
        .bubble_ex(bub_c), .freeze_all(frz_c), .lu_stall_cnt(lucnt_c), .mem_stall_cnt(memcnt_c));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        id_rsrc = '0; ex_rsrc = '0; id_vld = '0;
        ex_ro = '0; mem_ro = '0; wb_ro = '0;
        ex_wen = 0; ex_ld = 0; mem_wen = 0; mem_ld = 0; mem_busy = 0; wb_wen = 0;
        c_id_rsrc = '0; c_ex_rsrc = '0; c_id_vld = '0;
        c_ex_ro = '0; c_mem_ro = '0; c_wb_ro = '0;
        c_ex_wen = 0; c_ex_ld = 0; c_mem_wen = 0; c_mem_ld = 0; c_mem_busy = 0; c_wb_wen = 0;
    endtask

    initial begin
        compared = 0;
        mismatched = 0;
        rst = 1'b1;
        idle();
        // reset: outputs gated to 0 even with busy and a load-use pattern
        mem_busy = 1; ex_wen = 1; ex_ld = 1; ex_ro = 3'd5; id_rsrc = {3'd5, 3'd0}; id_vld = 2'b10;
        #2;
        chk("rst_freeze", frz_a, 0);
        chk("rst_stall", stall_a, 0);
        chk("rst_bubble", bub_a, 0);
        chk("rst_lucnt", lucnt_a, 0);
        chk("rst_memcnt", memcnt_a, 0);
        tick();
        idle();
        rst = 1'b0;

        // forwarding priority MEM > WB > PASS on both operands
        ex_rsrc = {3'd3, 3'd3}; mem_ro = 3'd3; mem_wen = 1; wb_ro = 3'd3; wb_wen = 1;
        #1 chk("prio_mem", fsel_a, 4'b0101);
        mem_wen = 0;
        #1 chk("prio_wb", fsel_a, 4'b1010);
        wb_wen = 0;
        #1 chk("prio_pass", fsel_a, 4'b0000);

        // WB2: r2 written by WB, seen by EX one cycle later
        tick();
        ex_rsrc = '0; wb_ro = 3'd2; wb_wen = 1;
        tick();
        wb_wen = 0; wb_ro = 3'd0; ex_rsrc = {3'd1, 3'd2};
        #1 chk("wb2_fwd", fsel_a, 4'b0011);
        chk("wb2_bypass_cfg", fsel_b, 4'b0000);
        wb_ro = 3'd2; wb_wen = 1;
        #1 chk("wb_over_wb2", fsel_a, 4'b0010);
        wb_wen = 0; wb_ro = 3'd0;

        // load-use on operand 1
        tick();
        idle();
        ex_wen = 1; ex_ld = 1; ex_ro = 3'd5; id_rsrc = {3'd5, 3'd0}; id_vld = 2'b10;
        #1 chk("lu_stall", stall_a, 1);
        chk("lu_bubble", bub_a, 1);
        chk("lu_freeze", frz_a, 0);
        tick();
        chk("lu_once_stall", stall_a, 0);
        chk("lu_once_bubble", bub_a, 0);
        chk("lu_cnt1", lucnt_a, 1);
        idle();
        tick();
        // same registers but operand 1 not read: no hazard
        ex_wen = 1; ex_ld = 1; ex_ro = 3'd5; id_rsrc = {3'd5, 3'd0}; id_vld = 2'b01;
        #1 chk("lu_invalid", stall_a, 0);
        tick();
        chk("lu_cnt_hold", lucnt_a, 1);
        idle();
        tick();

        // memory wait coincident with load-use, WB2 frozen
        ex_wen = 1; ex_ld = 1; ex_ro = 3'd5; id_rsrc = {3'd5, 3'd0}; id_vld = 2'b10;
        mem_busy = 1; wb_ro = 3'd4; wb_wen = 1;
        #1 chk("mw_freeze1", frz_a, 1);
        chk("mw_stall1", stall_a, 0);
        chk("mw_bubble1", bub_a, 0);
        tick();
        wb_wen = 0; wb_ro = 3'd0; ex_rsrc = {3'd0, 3'd4};
        chk("mw_freeze2", frz_a, 1);
        chk("mw_stall2", stall_a, 0);
        chk("mw_wb2_hold", fsel_a, 4'b0000);
        tick();
        chk("mw_freeze3", frz_a, 1);
        tick();
        chk("mw_freeze4", frz_a, 1);
        chk("mw_stall4", stall_a, 0);
        tick();
        mem_busy = 0;
        #1 chk("mw_release", frz_a, 0);
        chk("mw_lu_follows", stall_a, 1);
        chk("mw_cnt", memcnt_a, 4);
        tick();
        chk("mw_lu_cnt", lucnt_a, 2);
        chk("mw_lu_done", stall_a, 0);
        idle();
        tick();

        // saturation: 20 busy cycles
        mem_busy = 1;
        for (int k = 0; k < 20; k++) tick();
        chk("sat_b", memcnt_b, 15);
        chk("sat_a", memcnt_a, 24);
        chk("sat_frz_b", frz_b, 1);
        chk("lucnt_b", lucnt_b, 2);
        mem_ro = 3'd3; mem_wen = 1; ex_rsrc = {3'd0, 3'd3};
        #1 chk("pre_rst_fsel", fsel_a, 4'b0001);
        // asynchronous reset in the middle of MWAIT
        rst = 1'b1;
        #1 chk("arst_freeze", frz_a, 0);
        chk("arst_fsel", fsel_a, 4'b0000);
        chk("arst_memcnt_a", memcnt_a, 0);
        chk("arst_memcnt_b", memcnt_b, 0);
        chk("arst_lucnt", lucnt_a, 0);
        mem_busy = 0;
        ex_wen = 1; ex_ld = 1; ex_ro = 3'd5; id_rsrc = {3'd5, 3'd0}; id_vld = 2'b10;
        rst = 1'b0;
        #1 chk("post_rst_fsel", fsel_a, 4'b0001);
        chk("post_rst_stall", stall_a, 1);
        chk("post_rst_bub_b", bub_b, 1);
        chk("post_rst_freeze", frz_a, 0);
        tick();
        idle();
        tick();

        // hardwired zero register, three operands
        c_ex_rsrc = {4'd9, 4'd1, 4'd0}; c_mem_ro = 4'd0; c_mem_wen = 1;
        #1 chk("zh_r0_nofwd", fsel_c, 6'b000000);
        c_mem_ro = 4'd9;
        #1 chk("zh_op2_mem", fsel_c, 6'b010000);
        c_wb_ro = 4'd1; c_wb_wen = 1;
        #1 chk("zh_op1_wb", fsel_c, 6'b011000);
        c_ex_wen = 1; c_ex_ld = 1; c_ex_ro = 4'd0; c_id_rsrc = '0; c_id_vld = 3'b001;
        #1 chk("zh_r0_nolu", stall_c, 0);
        chk("zh_bub", bub_c, 0);
        chk("zh_frz", frz_c, 0);
        tick();
        chk("zh_cnts", {lucnt_c, memcnt_c}, 0);
        idle();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
